and2_rr_sched: RTL

- Round-robin scheduler that shares one two-input AND gate unit among N_REQ requesters.
- The shared unit is connected through the gate-side ports of its interface (a, b in; y out).
- Arbitrates the requests, drives the selected operands onto the gate and captures y one cycle later.
- Returns each result with a valid/ready handshake. Sits between the requester logic and the single gate instance.

---
 rtl/and2_rr_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/and2_rr_sched.sv
// Round-robin scheduler sharing one two-input AND gate among N_REQ requesters.
// Grants one request at a time, drives its operands, captures y and returns it via valid/ready.
module and2_rr_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ),
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] gnt,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_y,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  localparam int unsigned SW = IDW + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_y_q, rsp_y_d;
  logic             busy_q, busy_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             found_c;
  logic [IDW-1:0]   win_c;
  logic [SW-1:0]    cand;

  // First set request scanning upward from ptr with wrap-around.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = SW'(ptr_q) + SW'(i);
      if (cand >= SW'(N_REQ)) cand = cand - SW'(N_REQ);
      if (!found_c && req[cand[IDW-1:0]]) begin
        found_c = 1'b1;
        win_c   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    gnt_d       = '0;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt_d    = N_REQ'(1) << win_c;
          gate_a_d = req_a[win_c];
          gate_b_d = req_b[win_c];
          idx_d    = win_c;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        rsp_y_d     = gate_y;
        rsp_id_d    = idx_q;
        rsp_valid_d = 1'b1;
        ptr_d       = (idx_q == IDW'(N_REQ - 1)) ? '0 : idx_q + IDW'(1);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + CNTW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = busy_q;
  assign op_count  = cnt_q;

endmodule
